// File: rtl/wb_stage.sv
// MEM/WB pipeline register fused with RF write-data select (alu / load / link / imm), optional retire counter (WB_RETIRE_CNT_EN).
// Latency: 1 cycle from m_* inputs to WB outputs; WD is combinational from the registered fields.
// Backpressure: stall holds every stage register, flush loads a bubble; no valid/ready handshake.
module wb_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int PC_STEP = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic              m_RegWrite,
  input  logic [4:0]        m_rd,
  input  logic [1:0]        m_WDSel,
  input  logic [2:0]        m_DMType,
  input  logic [DATA_W-1:0] m_aluout,
  input  logic [DATA_W-1:0] m_dout,
  input  logic [ADDR_W-1:0] m_PC,
  input  logic [DATA_W-1:0] m_imm,
  output logic              w_valid,
  output logic              RegWrite,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] WD,
  output logic [ADDR_W-1:0] w_PC,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic              valid_q;
  logic              regwrite_q;
  logic [4:0]        rd_q;
  logic [1:0]        wdsel_q;
  logic [2:0]        dmtype_q;
  logic [DATA_W-1:0] aluout_q;
  logic [DATA_W-1:0] dout_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] imm_q;

  logic [1:0]        off;
  logic [31:0]       word;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic [DATA_W-1:0] ld_val;
  logic [ADDR_W-1:0] link_pc;

  // Stage register: reset > flush > stall > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdsel_q    <= '0;
      dmtype_q   <= '0;
      aluout_q   <= '0;
      dout_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdsel_q    <= '0;
      dmtype_q   <= '0;
      aluout_q   <= '0;
      dout_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
    end else if (!stall) begin
      valid_q    <= m_valid;
      regwrite_q <= m_RegWrite;
      rd_q       <= m_rd;
      wdsel_q    <= m_WDSel;
      dmtype_q   <= m_DMType;
      aluout_q   <= m_aluout;
      dout_q     <= m_dout;
      pc_q       <= m_PC;
      imm_q      <= m_imm;
    end
  end

  assign off  = aluout_q[1:0];
  assign word = dout_q[31:0];

  // Pick the half (off[1]) and byte (off) out of the low word; off[0] ignored for halves
  always_comb begin
    half_sel = word[15:0];
    byte_sel = word[7:0];
    if (off[1]) half_sel = word[31:16];
    case (off)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // Sub-word load formatting; unknown load types fall back to lw
  always_comb begin
    ld_val = DATA_W'($signed(word));
    case (dmtype_q)
      3'b001:  ld_val = DATA_W'($signed(half_sel));
      3'b010:  ld_val = DATA_W'(half_sel);
      3'b011:  ld_val = DATA_W'($signed(byte_sel));
      3'b100:  ld_val = DATA_W'(byte_sel);
      default: ld_val = DATA_W'($signed(word));
    endcase
  end

  // Link value wraps at ADDR_W bits before being fitted to the datapath
  assign link_pc = pc_q + ADDR_W'(PC_STEP);

  // Write-data source select
  always_comb begin
    WD = aluout_q;
    case (wdsel_q)
      2'b01:   WD = ld_val;
      2'b10:   WD = DATA_W'(link_pc);
      2'b11:   WD = imm_q;
      default: WD = aluout_q;
    endcase
  end

  assign w_valid  = valid_q;
  assign RegWrite = valid_q & regwrite_q & (rd_q != 5'd0);
  assign rd       = rd_q;
  assign w_PC     = pc_q;

`ifdef WB_RETIRE_CNT_EN
  // Count instructions leaving WB; a flush does not stop the occupant from retiring
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (valid_q && !stall) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_RegWrite = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [1:0]  m_WDSel = '0;
  logic [2:0]  m_DMType = '0;
  logic [31:0] m_aluout = '0;
  logic [31:0] m_dout = '0;
  logic [31:0] m_PC = '0;
  logic [31:0] m_imm = '0;

  logic        d0_valid, d0_rw, d1_valid, d1_rw;
  logic [4:0]  d0_rd, d1_rd;
  logic [31:0] d0_wd, d1_wd, d0_pc, d1_pc, d0_cnt;
  logic [3:0]  d1_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_stage dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_rd(m_rd), .m_WDSel(m_WDSel),
    .m_DMType(m_DMType), .m_aluout(m_aluout), .m_dout(m_dout), .m_PC(m_PC), .m_imm(m_imm),
    .w_valid(d0_valid), .RegWrite(d0_rw), .rd(d0_rd), .WD(d0_wd), .w_PC(d0_pc),
    .retire_cnt(d0_cnt)
  );

  wb_stage #(.PC_STEP(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_rd(m_rd), .m_WDSel(m_WDSel),
    .m_DMType(m_DMType), .m_aluout(m_aluout), .m_dout(m_dout), .m_PC(m_PC), .m_imm(m_imm),
    .w_valid(d1_valid), .RegWrite(d1_rw), .rd(d1_rd), .WD(d1_wd), .w_PC(d1_pc),
    .retire_cnt(d1_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected counter value given how many instructions retired
  function automatic longint ec(input longint n, input longint modulus);
`ifdef WB_RETIRE_CNT_EN
    return n % modulus;
`else
    return 0;
`endif
  endfunction

  // Model: the instruction currently sitting in WB, plus a retirement tally
  bit          mv, mrw;
  int          mrd, msel, mtype;
  longint      malu, mdout, mpc, mimm;
  longint      retired = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv = 0; mrw = 0; mrd = 0; msel = 0; mtype = 0;
      malu = 0; mdout = 0; mpc = 0; mimm = 0; retired = 0;
    end else begin
      if (mv && !stall) retired++;
      if (flush) begin
        mv = 0; mrw = 0; mrd = 0; msel = 0; mtype = 0;
        malu = 0; mdout = 0; mpc = 0; mimm = 0;
      end else if (!stall) begin
        mv = m_valid; mrw = m_RegWrite; mrd = m_rd; msel = m_WDSel; mtype = m_DMType;
        malu = m_aluout; mdout = m_dout; mpc = m_PC; mimm = m_imm;
      end
    end
  end

  function automatic longint model_wd(input longint step);
    longint off, v;
    off = malu % 4;
    case (msel)
      0: return malu;
      2: return (mpc + step) % 64'h1_0000_0000;
      3: return mimm;
      default: begin
        if (mtype == 1 || mtype == 2) begin
          v = (mdout >> (16 * (off / 2))) % 65536;
          if (mtype == 1 && v >= 32768) v = v + 64'hFFFF_0000;
          return v;
        end else if (mtype == 3 || mtype == 4) begin
          v = (mdout >> (8 * off)) % 256;
          if (mtype == 3 && v >= 128) v = v + 64'hFFFF_FF00;
          return v;
        end
        return mdout;
      end
    endcase
  endfunction

  // Every cycle: both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d0_w_valid", d0_valid, mv);
      chk("d0_RegWrite", d0_rw, mv && mrw && mrd != 0);
      chk("d0_rd", d0_rd, mrd);
      chk("d0_WD", d0_wd, model_wd(4));
      chk("d0_w_PC", d0_pc, mpc);
      chk("d0_retire_cnt", d0_cnt, ec(retired, 64'h1_0000_0000));
      chk("d1_w_valid", d1_valid, mv);
      chk("d1_RegWrite", d1_rw, mv && mrw && mrd != 0);
      chk("d1_WD", d1_wd, model_wd(1));
      chk("d1_retire_cnt", d1_cnt, ec(retired, 16));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input bit rw, input int r, input int sel, input int ty,
                       input logic [31:0] alu, input logic [31:0] dout,
                       input logic [31:0] pc, input logic [31:0] imm);
    m_valid = v; m_RegWrite = rw; m_rd = 5'(r); m_WDSel = 2'(sel); m_DMType = 3'(ty);
    m_aluout = alu; m_dout = dout; m_PC = pc; m_imm = imm;
  endtask

  typedef struct { int ty; logic [31:0] alu; logic [31:0] exp; string nm; } ld_t;
  ld_t lds[7];

  initial begin
    lds[0] = '{3, 32'd0, 32'h0000_0002, "lb_off0"};
    lds[1] = '{3, 32'd3, 32'hFFFF_FF80, "lb_off3"};
    lds[2] = '{4, 32'd3, 32'h0000_0080, "lbu_off3"};
    lds[3] = '{1, 32'd2, 32'hFFFF_80F1, "lh_off2"};
    lds[4] = '{2, 32'd3, 32'h0000_80F1, "lhu_off3"};
    lds[5] = '{0, 32'd1, 32'h80F1_7F02, "lw"};
    lds[6] = '{7, 32'd2, 32'h80F1_7F02, "type7_as_lw"};

    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_w_valid", d0_valid, 0);
    chk("reset_WD", d0_wd, 0);
    chk("reset_cnt", d0_cnt, 0);

    // Link value, both PC_STEP flavours
    drive(1, 1, 1, 2, 0, 0, 0, 32'h100, 0);
    step();
    chk("link4_WD", d0_wd, 32'h104);
    chk("link4_RegWrite", d0_rw, 1);
    chk("link4_rd", d0_rd, 1);
    chk("link1_WD", d1_wd, 32'h101);

    // Load formatting
    foreach (lds[i]) begin
      drive(1, 1, 5, 1, lds[i].ty, lds[i].alu, 32'h80F1_7F02, 32'h200, 0);
      step();
      chk(lds[i].nm, d0_wd, lds[i].exp);
    end
    drive(1, 1, 6, 0, 0, 32'h1234_5678, 0, 0, 0);
    step();
    chk("sel_alu", d0_wd, 32'h1234_5678);
    drive(1, 1, 6, 3, 0, 0, 0, 0, 32'hDEAD_0000);
    step();
    chk("sel_imm", d0_wd, 32'hDEAD_0000);

    // Asynchronous reset mid-cycle with valid data held
    rst = 1'b1;
    #1;
    chk("arst_w_valid", d0_valid, 0);
    chk("arst_RegWrite", d0_rw, 0);
    chk("arst_rd", d0_rd, 0);
    chk("arst_WD", d0_wd, 0);
    chk("arst_w_PC", d0_pc, 0);
    chk("arst_cnt", d0_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;

    // Stall / flush
    drive(1, 1, 7, 0, 0, 32'hAAAA, 0, 32'h40, 0);
    step();
    chk("A_WD", d0_wd, 32'hAAAA);
    stall = 1'b1;
    drive(1, 1, 9, 0, 0, 32'hBBBB, 0, 32'h44, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_WD", d0_wd, 32'hAAAA);
      chk("stall_rd", d0_rd, 7);
      chk("stall_RegWrite", d0_rw, 1);
      chk("stall_cnt", d0_cnt, 0);
    end
    stall = 1'b0;
    drive(1, 1, 10, 0, 0, 32'hCCCC, 0, 32'h48, 0);
    step();
    chk("A_retired_cnt", d0_cnt, ec(1, 64'h1_0000_0000));
    chk("C_WD", d0_wd, 32'hCCCC);
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk("stflush_w_valid", d0_valid, 0);
    chk("stflush_RegWrite", d0_rw, 0);
    chk("stflush_cnt", d0_cnt, ec(1, 64'h1_0000_0000));
    stall = 1'b0;
    flush = 1'b0;
    drive(1, 1, 11, 0, 0, 32'hDDDD, 0, 32'h4C, 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_w_valid", d0_valid, 0);
    chk("flush_counts_D", d0_cnt, ec(2, 64'h1_0000_0000));

    // x0 suppression and invalid instructions
    drive(1, 1, 0, 0, 0, 32'h5, 0, 0, 0);
    step();
    chk("x0_RegWrite", d0_rw, 0);
    chk("x0_w_valid", d0_valid, 1);
    drive(0, 1, 3, 0, 0, 32'h6, 0, 0, 0);
    step();
    chk("inv_RegWrite", d0_rw, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("inv_no_count", d0_cnt, ec(3, 64'h1_0000_0000));

    // Counter wrap on the 4-bit instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 2, 0, 0, 32'(i), 0, 32'(4 * i), 0);
      step();
    end
    chk("wrap_pre_d1", d1_cnt, ec(15, 16));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("wrap_d1", d1_cnt, 0);
    chk("wrap_d0", d0_cnt, ec(16, 64'h1_0000_0000));

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
